serial_magnitude_comparator: RTL and testbench
==============================================

Name: serial_magnitude_comparator

Overview:
Parametrised, bit-serial successor to the 2-bit combinational comparator. Compares two WIDTH-bit operands MSB-first, one bit per clock, with a start/busy/done handshake. Produces registered one-hot lt/eq/gt flags. Supports unsigned or two's-complement operands. Used where wide compares must be cheap in area and latency is acceptable.

Parameters:
WIDTH, 8, operand width in bits; legal range is 1 or more.
SIGNED, 0, 0 = unsigned compare; 1 = two's-complement compare.

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous reset, active low.
start  input  1  request a compare; sampled only in IDLE.
a  input  WIDTH  operand A; captured on the accepted start.
b  input  WIDTH  operand B; captured on the accepted start.
busy  output  1  high while a compare is in progress.
done  output  1  single-cycle pulse when the result is valid.
lt  output  1  A < B.
eq  output  1  A == B.
gt  output  1  A > B.

Behaviour:
- Reset (asynchronous, rst_n low):
  - State goes to IDLE.
  - busy, done, lt, eq and gt all go to 0.
  - Shift registers and bit counter are cleared.
  - Reset mid-compare abandons the operation; no done pulse is produced.
- States: IDLE, COMPARE.
- IDLE:
  - A clock edge with start=1 captures a and b into internal shift registers and loads the counter with WIDTH-1.
  - On that edge: busy goes to 1; lt, eq and gt clear to 0.
  - State moves to COMPARE.
- COMPARE:
  - Each cycle examines the current MSB of both shift registers, then shifts both left by 1 and decrements the counter.
  - The first differing bit decides the result.
  - Unsigned: A bit 1 vs B bit 0 means gt; otherwise lt.
  - SIGNED=1, only at original bit WIDTH-1: the sense is inverted. A sign bit of 1 means A is negative, so the result is lt.
  - Lower bits always use the unsigned rule.
  - No difference across all WIDTH bits means eq.
- Completion edge:
  - lt/eq/gt are written (exactly one set), done=1 for one cycle, busy=0, and state returns to IDLE.
- Results: flags hold their value until the next accepted start.
- start handling:
  - start is ignored while busy=1.
  - start asserted on the same edge that completes a compare is ignored; it is accepted on the following edge if still high.
  - A back-to-back request therefore has a 1-cycle IDLE gap after done.
- Latency (without the optional feature): fixed. done rises exactly WIDTH edges after the edge that accepted start.
  - An internal "decided" flag records the first difference.
  - Later bits are shifted but ignored.
- Counter width: max(1, clog2(WIDTH)).
- WIDTH=1: one COMPARE cycle. With SIGNED=1, that single bit is the sign bit.
- Operand inputs may change freely after the accepted start; they do not affect the result.

Optional Feature:
SERIAL_CMP_EARLY_EXIT_EN
- Defined: the compare terminates on the edge after the first differing bit.
  - done rises j+1 edges after the accepted start, where j is the 0-based position of the first difference counted from the MSB.
  - An equal result still takes WIDTH edges.
- Undefined: fixed WIDTH-edge latency for every compare (constant-time mode); the "decided" flag logic is used.
- Flag values are identical in both modes.

Test Plan:
1. WIDTH=8, SIGNED=0, a=0x80, b=0x7F, start for 1 cycle -> gt=1, lt=eq=0, done pulse of 1 cycle. done at edge +8 without the macro; edge +1 with SERIAL_CMP_EARLY_EXIT_EN.
2. WIDTH=8, a=b=0xA5 -> eq=1. done at edge +8 in both modes. busy high for exactly 8 cycles.
3. WIDTH=8, SIGNED=1, a=0x80 (-128), b=0x7F (+127) -> lt=1. Also a=0xFF (-1), b=0xFE (-2) -> gt=1.
4. WIDTH=8, a=0x12, b=0x13 -> lt=1, done at edge +8 in both modes. Then hold start high continuously -> second compare accepted on the edge after done; flags read 0 while busy.
5. Start compare a=0x01, b=0x02; at cycle 3 pulse start with a=0xFF, b=0x00; change a and b mid-compare -> ignored, result is lt=1. Then assert rst_n=0 during a further compare at cycle 4 -> busy, done and flags go to 0 immediately; no done pulse follows; a fresh start after release completes correctly.
6. WIDTH=2, both SIGNED values: exhaustive sweep of all 16 {a,b} pairs -> flags match the reference arithmetic compare for every pair; exactly one of lt/eq/gt is set at each done.

Source files
------------

// File: rtl/serial_magnitude_comparator.sv
// Bit-serial MSB-first magnitude comparator with a start/busy/done handshake.
// Define SERIAL_CMP_EARLY_EXIT_EN to end a compare right after the first differing bit.
module serial_magnitude_comparator #(
  parameter int WIDTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  localparam int              CW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   CNT_MAX = CW'(WIDTH - 1);

  typedef enum logic {IDLE, COMPARE} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sh_a, sh_b;
  logic [CW-1:0]    cnt;
  logic             decided, dec_gt;
  logic             bit_diff, bit_gt, last, finish;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    bit_diff  = sh_a[WIDTH-1] ^ sh_b[WIDTH-1];
    // The sign bit has inverted sense: a 1 in A means A is the negative (smaller) operand.
    bit_gt    = (SIGNED && (cnt == CNT_MAX)) ? sh_b[WIDTH-1] : sh_a[WIDTH-1];
    last      = (cnt == '0);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    finish    = last || (bit_diff && !decided);
`else
    finish    = last;
`endif
    state_nxt = state;
    case (state)
      IDLE:    if (start)  state_nxt = COMPARE;
      COMPARE: if (finish) state_nxt = IDLE;
      default:             state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: the operand shift registers are plain flops, not a memory, so they are reset along with everything else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_a    <= '0;
      sh_b    <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      dec_gt  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      lt      <= 1'b0;
      eq      <= 1'b0;
      gt      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sh_a    <= a;
            sh_b    <= b;
            cnt     <= CNT_MAX;
            decided <= 1'b0;
            dec_gt  <= 1'b0;
            busy    <= 1'b1;
            lt      <= 1'b0;
            eq      <= 1'b0;
            gt      <= 1'b0;
          end
        end
        COMPARE: begin
          sh_a <= sh_a << 1;
          sh_b <= sh_b << 1;
          cnt  <= cnt - CW'(1);
          // Only the first difference is recorded; later bits are shifted through and ignored.
          if (bit_diff && !decided) begin
            decided <= 1'b1;
            dec_gt  <= bit_gt;
          end
          if (finish) begin
            busy <= 1'b0;
            done <= 1'b1;
            if (decided) begin
              gt <= dec_gt;
              lt <= !dec_gt;
            end else if (bit_diff) begin
              gt <= bit_gt;
              lt <= !bit_gt;
            end else begin
              eq <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Scoreboard bench for serial_magnitude_comparator: unsigned/signed 8-bit and 2-bit instances.
// Expected flags and latency come from an integer reference compare queued at each start.
module tb_serial_magnitude_comparator;

  typedef struct {
    int   sel;
    logic lt, eq, gt;
    int   lat;
    int   accept_edge;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] start_v;
  logic [7:0] a8, b8;
  logic [1:0] a2, b2;
  logic [3:0] busy_v, done_v, lt_v, eq_v, gt_v;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   edge_cnt = 0;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt++;

  serial_magnitude_comparator #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .a(a8), .b(b8),
    .busy(busy_v[0]), .done(done_v[0]), .lt(lt_v[0]), .eq(eq_v[0]), .gt(gt_v[0]));
  serial_magnitude_comparator #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .a(a8), .b(b8),
    .busy(busy_v[1]), .done(done_v[1]), .lt(lt_v[1]), .eq(eq_v[1]), .gt(gt_v[1]));
  serial_magnitude_comparator #(.WIDTH(2), .SIGNED(1'b0)) u_u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .a(a2), .b(b2),
    .busy(busy_v[2]), .done(done_v[2]), .lt(lt_v[2]), .eq(eq_v[2]), .gt(gt_v[2]));
  serial_magnitude_comparator #(.WIDTH(2), .SIGNED(1'b1)) u_s2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[3]), .a(a2), .b(b2),
    .busy(busy_v[3]), .done(done_v[3]), .lt(lt_v[3]), .eq(eq_v[3]), .gt(gt_v[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t make_exp(input int sel, input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    int   w, ia, ib;
    bit   sg;
    w  = (sel < 2) ? 8 : 2;
    sg = (sel == 1) || (sel == 3);
    ia = int'(av) & ((1 << w) - 1);
    ib = int'(bv) & ((1 << w) - 1);
    e.sel = sel;
    e.lat = w;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int k = w - 1; k >= 0; k--) begin
      if (((ia >> k) & 1) != ((ib >> k) & 1)) begin
        e.lat = w - k;
        break;
      end
    end
`endif
    if (sg && ia[w-1]) ia -= (1 << w);
    if (sg && ib[w-1]) ib -= (1 << w);
    e.lt = (ia < ib);
    e.eq = (ia == ib);
    e.gt = (ia > ib);
    e.accept_edge = edge_cnt + 1;
    return e;
  endfunction

  // Scoreboard monitor: every done pulse pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (done_v[i]) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_done", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("sb_instance", i, e.sel);
          check("flags", {lt_v[i], eq_v[i], gt_v[i]}, {e.lt, e.eq, e.gt});
          check("onehot", int'(lt_v[i]) + int'(eq_v[i]) + int'(gt_v[i]), 1);
          check("latency", edge_cnt - e.accept_edge, e.lat);
        end
      end
    end
  end

  task automatic drive(input int sel, input logic [7:0] av, input logic [7:0] bv);
    if (sel < 2) begin
      a8 = av;
      b8 = bv;
    end else begin
      a2 = av[1:0];
      b2 = bv[1:0];
    end
    start_v[sel] = 1'b1;
  endtask

  task automatic wait_done(input int sel, input int exp_cycles);
    int n = 0;
    @(negedge clk);
    while (busy_v[sel] && n < 64) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", n, exp_cycles);
    check("done_pulse", done_v[sel], 1);
    @(negedge clk);
    check("done_single", done_v[sel], 0);
  endtask

  task automatic run_cmp(input int sel, input logic [7:0] av, input logic [7:0] bv);
    exp_t e;
    e = make_exp(sel, av, bv);
    sb.push_back(e);
    drive(sel, av, bv);
    @(posedge clk);
    #1;
    start_v[sel] = 1'b0;
    check("busy_on_start", busy_v[sel], 1);
    check("flags_clr_busy", {lt_v[sel], eq_v[sel], gt_v[sel]}, 3'b000);
    wait_done(sel, e.lat);
  endtask

  initial begin
    exp_t e;
    rst_n   = 1'b0;
    start_v = '0;
    a8 = '0; b8 = '0; a2 = '0; b2 = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy_v, 4'h0);
    check("rst_done", done_v, 4'h0);
    check("rst_lt", lt_v, 4'h0);
    check("rst_eq", eq_v, 4'h0);
    check("rst_gt", gt_v, 4'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic unsigned and signed compares, including the sign-bit boundary.
    run_cmp(0, 8'h80, 8'h7F);
    run_cmp(0, 8'hA5, 8'hA5);
    run_cmp(1, 8'h80, 8'h7F);
    run_cmp(1, 8'hFF, 8'hFE);
    run_cmp(1, 8'h05, 8'hFB);
    run_cmp(0, 8'h00, 8'hFF);
    for (int i = 0; i < 6; i++) run_cmp(i % 2, 8'($urandom), 8'($urandom));

    // start held high: second compare is accepted on the edge after done.
    e = make_exp(0, 8'h12, 8'h13);
    sb.push_back(e);
    drive(0, 8'h12, 8'h13);
    @(posedge clk);
    #1;
    check("hold_busy", busy_v[0], 1);
    begin
      int n = 0;
      @(negedge clk);
      while (busy_v[0] && n < 64) begin
        n++;
        @(negedge clk);
      end
      check("hold_busy_cycles", n, e.lat);
      check("hold_done", done_v[0], 1);
    end
    e = make_exp(0, 8'h12, 8'h13);
    sb.push_back(e);
    @(posedge clk);
    #1;
    check("hold_reaccept_busy", busy_v[0], 1);
    check("hold_flags_zero", {lt_v[0], eq_v[0], gt_v[0]}, 3'b000);
    check("hold_done_low", done_v[0], 0);
    start_v[0] = 1'b0;
    wait_done(0, e.lat);

    // start pulse and operand changes mid-compare must be ignored.
    e = make_exp(0, 8'h01, 8'h02);
    sb.push_back(e);
    drive(0, 8'h01, 8'h02);
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    drive(0, 8'hFF, 8'h00);
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    a8 = 8'h3C;
    b8 = 8'hC3;
    wait_done(0, e.lat - 3);

    // Reset mid-compare abandons the operation.
    e = make_exp(0, 8'h30, 8'h31);
    sb.push_back(e);
    drive(0, 8'h30, 8'h31);
    @(posedge clk);
    #1;
    start_v[0] = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("midrst_busy", busy_v[0], 0);
    check("midrst_done", done_v[0], 0);
    check("midrst_flags", {lt_v[0], eq_v[0], gt_v[0]}, 3'b000);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("midrst_no_done", done_v[0], 0);
    end
    run_cmp(0, 8'h55, 8'h54);

    // Exhaustive 2-bit sweep, unsigned and signed.
    for (int s = 2; s < 4; s++)
      for (int x = 0; x < 4; x++)
        for (int y = 0; y < 4; y++)
          run_cmp(s, 8'(x), 8'(y));

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
